multi_cycle_ctrl: RTL

Main control FSM for the multi-cycle version of the single-cycle CPU. It sequences a shared ALU, one unified instruction/data memory, the register file and the PC over several cycles per instruction. Decode comes from the IR opcode/funct fields, and memory accesses stall on a ready handshake. It sits beside the datapath inside the CPU top and drives every datapath enable and mux select.

---
 rtl/multi_cycle_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle CPU. It sequences the shared ALU, the unified memory,
// the register file and the PC over several cycles for each instruction.
module multi_cycle_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        ir_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        iord_o,
    output logic        reg_write_o,
    output logic [1:0]  reg_dst_o,
    output logic [1:0]  mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic [31:0] retire_cnt_o
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
        S_JR     = 4'd12, S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_R = 6'd0,  OP_J = 6'd2,  OP_JAL = 6'd3,  OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5, OP_ADDI = 6'd8, OP_SLTI = 6'd10;
    localparam logic [5:0] OP_LW = 6'd35, OP_SW = 6'd43, F_JR = 6'd8;

    localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001, ALU_SLT = 4'b0111;

    function automatic logic r_funct_legal(input logic [5:0] f);
        return (f == 6'd32) || (f == 6'd34) || (f == 6'd36) || (f == 6'd37) || (f == 6'd42);
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'd34:   return ALU_SUB;
            6'd36:   return ALU_AND;
            6'd37:   return ALU_OR;
            6'd42:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    state_t state_q, state_d;
    logic   retire;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_FETCH;
            illegal_o    <= 1'b0;
            retire_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT)
                illegal_o <= 1'b1;
            if (retire)
                retire_cnt_o <= retire_cnt_o + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_R: begin
                        if (funct_i == F_JR)
                            state_d = S_JR;
                        else if (r_funct_legal(funct_i))
                            state_d = S_EXEC;
                        else
                            state_d = S_HALT;
                    end
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J, OP_JAL:     state_d = S_JUMP;
                    default:          state_d = S_HALT;
                endcase
            end
            S_MEMADR: state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Everything is forced low while reset is held, including the Mealy strobes.
    always_comb begin
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 2'b00;
        mem_to_reg_o = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_ctrl_o   = ALU_ADD;
        retire       = 1'b0;
        if (rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: alu_src_b_o = 2'b11;
                S_MEMADR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEMRD: begin
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'b01;
                    retire       = 1'b1;
                end
                S_MEMWR: begin
                    mem_write_o = 1'b1;
                    iord_o      = 1'b1;
                    retire      = mem_ready_i;
                end
                S_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_ctrl_o  = funct_alu(funct_i);
                end
                S_ALUWB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 2'b01;
                    retire      = 1'b1;
                end
                S_IEXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_ctrl_o  = (op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_IWB: begin
                    reg_write_o = 1'b1;
                    retire      = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_ctrl_o  = ALU_SUB;
                    pc_src_o    = 2'b01;
                    pc_write_o  = ((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i);
                    retire      = 1'b1;
                end
                S_JUMP: begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 2'b10;
                    retire     = 1'b1;
                    if (op_i == OP_JAL) begin
                        reg_write_o  = 1'b1;
                        reg_dst_o    = 2'b10;
                        mem_to_reg_o = 2'b10;
                    end
                end
                S_JR: begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 2'b11;
                    retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = state_q;
endmodule
